// File: rtl/agex_pkg.sv
// agex_pkg: shared constants and types for the agex_mem_exec stage.
//   aluk_* : ALU operation codes as presented on the aluk port
//   state_e: sequencing states of agex_mem_exec
//   MOD_* / RM_*: ModRM field values that steer effective-address formation
//   FLG_*  : bit positions inside the 4-bit {OF,SF,ZF,CF} flag vector
package agex_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;
   localparam logic [2:0] ALU_SHR = 3'b110;
   localparam logic [2:0] ALU_SAR = 3'b111;

   localparam logic [1:0] MOD_IND    = 2'b00;
   localparam logic [1:0] MOD_DISP8  = 2'b01;
   localparam logic [1:0] MOD_DISP32 = 2'b10;
   localparam logic [1:0] MOD_REG    = 2'b11;

   localparam logic [2:0] RM_SIB    = 3'b100;
   localparam logic [2:0] RM_DISP32 = 3'b101;

   localparam int FLG_CF = 0;
   localparam int FLG_ZF = 1;
   localparam int FLG_SF = 2;
   localparam int FLG_OF = 3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_EX   = 3'd2,
      S_WR   = 3'd3,
      S_RSP  = 3'd4
   } state_e;

endpackage

// File: rtl/agex_alu.sv
// agex_alu: combinational DATA_W ALU and shifter.
//   aluk   in  3       operation code (agex_pkg ALU_*)
//   op_d   in  DATA_W  destination operand (left-hand side)
//   op_s   in  DATA_W  source operand / shift count in low bits
//   result out DATA_W  op_d <op> op_s
//   flags  out 4       {OF,SF,ZF,CF}
module agex_alu
   import agex_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        aluk,
   input  logic [DATA_W-1:0] op_d,
   input  logic [DATA_W-1:0] op_s,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags
);

   localparam int SH_W = $clog2(DATA_W);
   localparam int MSB  = DATA_W - 1;

   logic [SH_W-1:0]    cnt;
   logic [DATA_W:0]    wide;
   logic signed [DATA_W:0] sar_w;
   logic               cf;
   logic               of;

   always_comb begin
      cnt    = op_s[SH_W-1:0];
      wide   = '0;
      sar_w  = '0;
      cf     = 1'b0;
      of     = 1'b0;
      result = '0;
      case (aluk)
         ALU_ADD: begin
            wide   = {1'b0, op_d} + {1'b0, op_s};
            result = wide[DATA_W-1:0];
            cf     = wide[DATA_W];
            of     = (op_d[MSB] == op_s[MSB]) && (result[MSB] != op_d[MSB]);
         end
         ALU_SUB: begin
            wide   = {1'b0, op_d} - {1'b0, op_s};
            result = wide[DATA_W-1:0];
            cf     = wide[DATA_W];
            of     = (op_d[MSB] != op_s[MSB]) && (result[MSB] != op_d[MSB]);
         end
         ALU_OR:  result = op_d | op_s;
         ALU_AND: result = op_d & op_s;
         ALU_XOR: result = op_d ^ op_s;
         // Shifts carry one guard bit so the last bit shifted out lands in
         // the guard position; a zero count leaves the guard bit at 0.
         ALU_SHL: begin
            wide   = {1'b0, op_d} << cnt;
            result = wide[DATA_W-1:0];
            cf     = wide[DATA_W];
         end
         ALU_SHR: begin
            wide   = {op_d, 1'b0} >> cnt;
            result = wide[DATA_W:1];
            cf     = wide[0];
         end
         ALU_SAR: begin
            sar_w  = $signed({op_d, 1'b0}) >>> cnt;
            result = sar_w[DATA_W:1];
            cf     = sar_w[0];
         end
         default: result = '0;
      endcase
      flags         = '0;
      flags[FLG_CF] = cf;
      flags[FLG_ZF] = (result == '0);
      flags[FLG_SF] = result[MSB];
      flags[FLG_OF] = of;
   end

endmodule

// File: rtl/agex_mem_exec.sv
// agex_mem_exec: address-generation / execute stage for one ModRM-form ALU op.
// Forms the effective address, fetches a memory operand over mem_req/mem_ack,
// executes via agex_alu, then writes back to memory (RMW) or returns the result.
//   clk, rst (sync, active-high)
//   in_valid/in_ready, mod, rm, aluk, mem_dst, use_imm, base_val, dst_val,
//   src_val, disp, imm, sib_index, sib_scale : instruction input
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack : memory bus
//   out_valid/out_ready, out_data, out_flags {OF,SF,ZF,CF} : result output
// Build option AGEX_SIB_EN: rm=100 with mod!=11 adds sib_index<<sib_scale to EA.
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready high
// RD    | memory operand read outstanding
// EX    | ALU evaluates latched operands
// WR    | RMW write-back outstanding
// RSP   | result held on out_* until out_ready
module agex_mem_exec
   import agex_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        mod,
   input  logic [2:0]        rm,
   input  logic [2:0]        aluk,
   input  logic              mem_dst,
   input  logic              use_imm,
   input  logic [ADDR_W-1:0] base_val,
   input  logic [DATA_W-1:0] dst_val,
   input  logic [DATA_W-1:0] src_val,
   input  logic [31:0]       disp,
   input  logic [DATA_W-1:0] imm,
   input  logic [ADDR_W-1:0] sib_index,
   input  logic [1:0]        sib_scale,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_flags
);

   state_e            state_q, state_d;
   logic              mem_op_q, mem_op_d;
   logic              mem_dst_q, mem_dst_d;
   logic              use_imm_q, use_imm_d;
   logic [2:0]        aluk_q, aluk_d;
   logic [DATA_W-1:0] dst_q, dst_d;
   logic [DATA_W-1:0] src_q, src_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [3:0]        out_flags_q, out_flags_d;

   logic [ADDR_W-1:0] disp_a;
   logic [ADDR_W-1:0] disp8_a;
   logic [ADDR_W-1:0] ea;
   logic [DATA_W-1:0] op_d;
   logic [DATA_W-1:0] op_s;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_flags;

   always_comb begin
      disp_a  = ADDR_W'(disp);
      disp8_a = {{(ADDR_W-8){disp[7]}}, disp[7:0]};
      case (mod)
         MOD_IND:    ea = (rm == RM_DISP32) ? disp_a : base_val;
         MOD_DISP8:  ea = base_val + disp8_a;
         MOD_DISP32: ea = base_val + disp_a;
         default:    ea = base_val;
      endcase
`ifdef AGEX_SIB_EN
      if (mod != MOD_REG && rm == RM_SIB)
         ea = ea + (sib_index << sib_scale);
`endif
   end

`ifndef AGEX_SIB_EN
   logic unused_sib;
   assign unused_sib = ^{sib_index, sib_scale};
`endif

   // Memory data is the destination for RMW, otherwise it is the source
   // unless an immediate overrides it.
   assign op_d = mem_dst_q ? rdata_q : dst_q;
   assign op_s = use_imm_q ? imm_q : (mem_op_q && !mem_dst_q) ? rdata_q : src_q;

   agex_alu #(.DATA_W(DATA_W)) u_alu (
      .aluk   (aluk_q),
      .op_d   (op_d),
      .op_s   (op_s),
      .result (alu_res),
      .flags  (alu_flags)
   );

   always_comb begin
      state_d     = state_q;
      mem_op_d    = mem_op_q;
      mem_dst_d   = mem_dst_q;
      use_imm_d   = use_imm_q;
      aluk_d      = aluk_q;
      dst_d       = dst_q;
      src_d       = src_q;
      imm_d       = imm_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_flags_d = out_flags_q;
      case (state_q)
         S_IDLE: if (in_valid) begin
            mem_op_d  = (mod != MOD_REG);
            mem_dst_d = mem_dst && (mod != MOD_REG);
            use_imm_d = use_imm;
            aluk_d    = aluk;
            dst_d     = dst_val;
            src_d     = src_val;
            imm_d     = imm;
            if (mod != MOD_REG) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = ea;
               state_d    = S_RD;
            end else begin
               state_d = S_EX;
            end
         end
         S_RD: if (mem_ack) begin
            rdata_d   = mem_rdata;
            mem_req_d = 1'b0;
            state_d   = S_EX;
         end
         S_EX: begin
            out_data_d  = alu_res;
            out_flags_d = alu_flags;
            if (mem_dst_q) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_wdata_d = alu_res;
               state_d     = S_WR;
            end else begin
               out_valid_d = 1'b1;
               state_d     = S_RSP;
            end
         end
         S_WR: if (mem_ack) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_RSP;
         end
         S_RSP: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_op_q    <= 1'b0;
         mem_dst_q   <= 1'b0;
         use_imm_q   <= 1'b0;
         aluk_q      <= '0;
         dst_q       <= '0;
         src_q       <= '0;
         imm_q       <= '0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_op_q    <= mem_op_d;
         mem_dst_q   <= mem_dst_d;
         use_imm_q   <= use_imm_d;
         aluk_q      <= aluk_d;
         dst_q       <= dst_d;
         src_q       <= src_d;
         imm_q       <= imm_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_flags_q <= out_flags_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_flags = out_flags_q;

endmodule

// File: tb/tb_agex_mem_exec.sv
// tb_agex_mem_exec: directed self-checking bench for agex_mem_exec.
module tb_agex_mem_exec;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        mod;
   logic [2:0]        rm;
   logic [2:0]        aluk;
   logic              mem_dst;
   logic              use_imm;
   logic [ADDR_W-1:0] base_val;
   logic [DATA_W-1:0] dst_val;
   logic [DATA_W-1:0] src_val;
   logic [31:0]       disp;
   logic [DATA_W-1:0] imm;
   logic [ADDR_W-1:0] sib_index;
   logic [1:0]        sib_scale;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_flags;

   int n_checks = 0;
   int n_errors = 0;

   agex_mem_exec #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mod       (mod),
      .rm        (rm),
      .aluk      (aluk),
      .mem_dst   (mem_dst),
      .use_imm   (use_imm),
      .base_val  (base_val),
      .dst_val   (dst_val),
      .src_val   (src_val),
      .disp      (disp),
      .imm       (imm),
      .sib_index (sib_index),
      .sib_scale (sib_scale),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] m, input logic [2:0] r, input logic [2:0] op,
                        input logic md, input logic ui, input logic [31:0] b,
                        input logic [31:0] d, input logic [31:0] s,
                        input logic [31:0] dp, input logic [31:0] im);
      mod = m; rm = r; aluk = op; mem_dst = md; use_imm = ui;
      base_val = b; dst_val = d; src_val = s; disp = dp; imm = im;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic ack(input logic [31:0] rd);
      mem_ack = 1'b1; mem_rdata = rd;
      step();
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      int k = 0;
      while (!out_valid && k < max_cycles) begin
         step();
         k++;
      end
      check(tag, {63'b0, out_valid}, 64'd1);
   endtask

   // Register-form op with immediate source: result two edges after accept.
   task automatic run_reg(input string tag, input logic [2:0] op, input logic md,
                          input logic [31:0] d, input logic [31:0] s,
                          input logic [31:0] exp_r, input logic [3:0] exp_f);
      issue(2'b11, 3'd0, op, md, 1'b1, 32'h0, d, 32'h0, 32'h0, s);
      check({tag, "_early"}, {62'b0, out_valid, mem_req}, 64'd0);
      step();
      check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
      check({tag, "_data"}, {32'b0, out_data}, {32'b0, exp_r});
      check({tag, "_flags"}, {60'b0, out_flags}, {60'b0, exp_f});
      consume();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; mod = '0; rm = '0; aluk = '0; mem_dst = 1'b0;
      use_imm = 1'b0; base_val = '0; dst_val = '0; src_val = '0; disp = '0;
      imm = '0; sib_index = '0; sib_scale = '0; mem_rdata = '0; mem_ack = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      check("rst_ctrl", {60'b0, in_ready, mem_req, mem_we, out_valid}, 64'b1000);
      check("rst_data", {28'b0, out_flags, out_data}, 64'd0);
      check("rst_bus", {mem_wdata, mem_addr}, 64'd0);
      rst = 1'b0;

      // 1: reg ADD with carry and zero, output held while out_ready low
      issue(2'b11, 3'd0, 3'b000, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
      check("t1_busy", {61'b0, in_ready, out_valid, mem_req}, 64'd0);
      step();
      check("t1_valid", {63'b0, out_valid}, 64'd1);
      check("t1_data", {32'b0, out_data}, 64'h0);
      check("t1_flags", {60'b0, out_flags}, 64'b0011);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t1_hold", {27'b0, out_valid, out_flags, out_data}, {27'b0, 1'b1, 4'b0011, 32'h0});
      end
      consume();
      check("t1_done", {62'b0, out_valid, in_ready}, 64'b01);

      // 2: memory-source ADD, mod=10 disp32; busy in_valid must be ignored
      issue(2'b10, 3'd5, 3'b000, 1'b0, 1'b0, 32'hB234ABCD, 32'hCCCCCCCC, 32'h0,
            32'h00FF00FF, 32'h0);
      check("t2_req", {62'b0, mem_req, mem_we}, 64'b10);
      check("t2_addr", {32'b0, mem_addr}, 64'hB333ACCC);
      in_valid = 1'b1; mod = 2'b11; dst_val = 32'h11111111;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_hold", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'hB333ACCC});
      end
      in_valid = 1'b0;
      ack(32'h0123BEEF);
      check("t2_after_ack", {62'b0, mem_req, out_valid}, 64'd0);
      step();
      check("t2_valid", {63'b0, out_valid}, 64'd1);
      check("t2_data", {32'b0, out_data}, 64'hCDF08BBB);
      check("t2_flags", {60'b0, out_flags}, 64'b0100);
      consume();

      // 3: RMW SUB, mod=01 negative disp8, immediate source
      issue(2'b01, 3'd0, 3'b100, 1'b1, 1'b1, 32'h1000, 32'h0, 32'h0, 32'h80, 32'h7);
      check("t3_rd", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h0F80});
      check("t3_rd_we", {63'b0, mem_we}, 64'd0);
      ack(32'h5);
      step();
      check("t3_wr", {30'b0, mem_req, mem_we, mem_addr}, {30'b0, 2'b11, 32'h0F80});
      check("t3_wdata", {32'b0, mem_wdata}, 64'hFFFFFFFE);
      check("t3_wr_novalid", {63'b0, out_valid}, 64'd0);
      step();
      ack(32'h0);
      check("t3_done_bus", {62'b0, mem_req, mem_we}, 64'd0);
      check("t3_valid", {63'b0, out_valid}, 64'd1);
      check("t3_data", {32'b0, out_data}, 64'hFFFFFFFE);
      check("t3_flags", {60'b0, out_flags}, 64'b0101);
      consume();

      // 4: shifts, logic ops, overflow cases, mod=11 with mem_dst=1
      run_reg("sar", 3'b111, 1'b0, 32'h80000000, 32'd4, 32'hF8000000, 4'b0100);
      run_reg("shl0", 3'b101, 1'b0, 32'h1, 32'd0, 32'h1, 4'b0000);
      run_reg("shr", 3'b110, 1'b0, 32'h3, 32'd1, 32'h1, 4'b0001);
      run_reg("shl_cf", 3'b101, 1'b1, 32'h80000001, 32'd1, 32'h2, 4'b0001);
      run_reg("xor", 3'b011, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0, 4'b0010);
      run_reg("and", 3'b010, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000);
      run_reg("or", 3'b001, 1'b0, 32'h80000000, 32'h1, 32'h80000001, 4'b0100);
      run_reg("sub_of", 3'b100, 1'b0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b1000);
      run_reg("add_of", 3'b000, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1100);

      // mod=00 rm=101: absolute disp32, base ignored
      issue(2'b00, 3'd5, 3'b001, 1'b0, 1'b0, 32'hFFFF0000, 32'hF0, 32'h0, 32'h1234, 32'h0);
      check("abs_addr", {32'b0, mem_addr}, 64'h1234);
      ack(32'h0F);
      step();
      check("abs_data", {31'b0, out_valid, out_data}, {31'b0, 1'b1, 32'hFF});
      consume();

      // 5: reset during RD abandons the read; late ack ignored
      issue(2'b00, 3'd3, 3'b000, 1'b0, 1'b0, 32'h2000, 32'h0, 32'h0, 32'h0, 32'h0);
      check("t5_rd", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h2000});
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_rst_ctrl", {60'b0, in_ready, mem_req, mem_we, out_valid}, 64'b1000);
      check("t5_rst_addr", {32'b0, mem_addr}, 64'd0);
      ack(32'hDEAD);
      check("t5_late_ack", {61'b0, in_ready, mem_req, out_valid}, 64'b100);
      run_reg("t5_next", 3'b000, 1'b0, 32'h2, 32'h3, 32'h5, 4'b0000);

      // 6: rm=100 mod=01, SIB scaling only with the build option
      sib_index = 32'h10; sib_scale = 2'd2;
      issue(2'b01, 3'd4, 3'b000, 1'b0, 1'b1, 32'h100, 32'h1, 32'h0, 32'h04, 32'h1);
`ifdef AGEX_SIB_EN
      check("t6_ea", {32'b0, mem_addr}, 64'h144);
`else
      check("t6_ea", {32'b0, mem_addr}, 64'h104);
`endif
      ack(32'h0);
      wait_valid("t6_valid", 4);
      check("t6_data", {32'b0, out_data}, 64'h2);
      consume();
      sib_index = '0; sib_scale = '0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
